lane_striper_1xn: RTL and testbench

- Parametrised single-clock byte-striping demultiplexer for the PHY transmit path. Successor to the fixed 1x4 8-bit demux tree.
- Distributes a serial stream of WIDTH-bit symbols round-robin across LANES lane slots, then presents each complete group as one parallel output word with per-lane valids.
- Adds features the fixed tree lacks: runtime link-width selection (x1/x2/x4/...), ready/valid backpressure, partial-group flush with padding, and a group counter.

---
 rtl/lane_striper_1xn.sv | 153 +++++++++++++++
 tb/tb_lane_striper_1xn.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_striper_1xn.sv
// lane_striper_1xn
// ----------------
// Stripes a serial stream of WIDTH-bit symbols round-robin across up to LANES
// lane slots and presents each completed group as one parallel word with
// per-lane valids. The link width can change at runtime (x1/x2/x4/...), but a
// new width only takes effect at a group boundary. A flush closes a partial
// group and pads the unfilled lanes. The output register is held under
// backpressure.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   data_in       input symbol
//   valid_in      data_in valid
//   ready_in      block can accept data_in this cycle (combinational)
//   flush         close the current partial group (honoured only when ready_in=1)
//   active_lanes  requested link width: 1,2,4,...,LANES; illegal values mean LANES
//   out_ready     downstream accepts the presented group
//   data_out      lane i at data_out[i*WIDTH +: WIDTH]
//   valid_out     per-lane valid of the presented group
//   group_cnt     number of groups launched, wraps at 16 bits

module lane_striper_1xn #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      LANES = 4,
    parameter logic [WIDTH-1:0] PAD   = 8'hF7,
    localparam int unsigned     LW    = $clog2(LANES) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic                   flush,
    input  logic [LW-1:0]          active_lanes,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic [15:0]            group_cnt
);

    localparam int unsigned PW = $clog2(LANES);

    // Write pointer into the assembly register.
    logic [PW-1:0]          ptr_q, ptr_d;
    // Width latched on the first symbol of a group.
    logic [LW-1:0]          act_q, act_d;
    // Assembly slots for the group under construction.
    logic [WIDTH-1:0]       asm_q [LANES];
    logic [WIDTH-1:0]       asm_d [LANES];
    // Presented output group.
    logic [LANES*WIDTH-1:0] dout_q, dout_d;
    logic [LANES-1:0]       vld_q, vld_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [LW-1:0] dec_act;
    logic [LW-1:0] eff_act;
    logic [LW-1:0] ptr_ext;
    logic [LW-1:0] fill_n;
    logic          accept;
    logic          last_sym;
    logic          flush_go;
    logic          launch;

    // Width decode: anything that is not a power of two in 1..LANES selects
    // the full width.
    always_comb begin
        dec_act = LW'(LANES);
        if ((active_lanes != '0) &&
            ((active_lanes & (active_lanes - LW'(1))) == '0) &&
            (active_lanes <= LW'(LANES))) begin
            dec_act = active_lanes;
        end
    end

    // Mid-group the latched width wins so a width change cannot split a group.
    assign ptr_ext  = LW'(ptr_q);
    assign eff_act  = (ptr_q == '0) ? dec_act : act_q;

    // The output register can be overwritten only when empty or being drained.
    assign ready_in = (vld_q == '0) || out_ready;
    assign accept   = valid_in && ready_in;
    assign last_sym = accept && (ptr_ext == eff_act - LW'(1));

    // A flush with nothing assembled and nothing arriving is a no-op.
    assign flush_go = flush && ready_in && (accept || (ptr_q != '0));
    assign launch   = last_sym || flush_go;

    // Number of slots filled in the launched group, counting this cycle's symbol.
    assign fill_n   = accept ? (ptr_ext + LW'(1)) : ptr_ext;

    always_comb begin
        ptr_d  = ptr_q;
        act_d  = act_q;
        asm_d  = asm_q;
        dout_d = dout_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;

        if (accept) begin
            asm_d[ptr_q] = data_in;
            if (ptr_q == '0) begin
                act_d = dec_act;
            end
            ptr_d = ptr_q + PW'(1);
        end

        if (launch) begin
            ptr_d = '0;
            // asm_d already carries the symbol accepted this cycle.
            for (int i = 0; i < LANES; i++) begin
                if (LW'(i) < fill_n) begin
                    dout_d[i*WIDTH +: WIDTH] = asm_d[i];
                    vld_d[i]                 = 1'b1;
                end else begin
                    dout_d[i*WIDTH +: WIDTH] = PAD;
                    vld_d[i]                 = 1'b0;
                end
            end
            cnt_d = cnt_q + 16'd1;
        end else if (out_ready) begin
            // data_out is left as is; only the valids are retired.
            vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            act_q  <= LW'(LANES);
            dout_q <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                asm_q[i] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            act_q  <= act_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < LANES; i++) begin
                asm_q[i] <= asm_d[i];
            end
        end
    end

    assign data_out  = dout_q;
    assign valid_out = vld_q;
    assign group_cnt = cnt_q;

endmodule

// File: tb/tb_lane_striper_1xn.sv
// Testbench for lane_striper_1xn with LANES=4, WIDTH=8, PAD=F7.
// Inputs change on the falling edge. Registered outputs are sampled #1 after
// the rising edge.

module tb_lane_striper_1xn;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_in;
    logic        flush;
    logic [2:0]  active_lanes;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic [15:0] group_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lane_striper_1xn #(
        .WIDTH(8),
        .LANES(4),
        .PAD  (8'hF7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .flush       (flush),
        .active_lanes(active_lanes),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .group_cnt   (group_cnt)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        fl;
        logic [2:0]  act;
        logic        ordy;
        logic        rdy;
        logic [3:0]  vo;
        logic [31:0] dout;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic fl,
                         input logic [2:0] act, input logic ordy);
        @(negedge clk);
        valid_in     = v;
        data_in      = d;
        flush        = fl;
        active_lanes = act;
        out_ready    = ordy;
    endtask

    // Check ready_in for the driven cycle, then the registered result of its edge.
    // data_out is compared only while a group is presented.
    task automatic settle(input string tag, input logic rdy, input logic [3:0] vo,
                          input logic [31:0] dout, input logic [15:0] cnt);
        #1;
        chk({tag, " ready_in"}, {31'd0, ready_in}, {31'd0, rdy});
        @(posedge clk);
        #1;
        chk({tag, " valid_out"}, {28'd0, valid_out}, {28'd0, vo});
        if (vo != 4'h0) chk({tag, " data_out"}, data_out, dout);
        chk({tag, " group_cnt"}, {16'd0, group_cnt}, {16'd0, cnt});
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic fl,
                                input logic [2:0] act, input logic [3:0] vo,
                                input logic [31:0] dout, input logic [15:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.fl = fl; r.act = act; r.ordy = 1'b1; r.rdy = 1'b1;
        r.vo = vo; r.dout = dout; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        // x4 stream
        tbl.push_back(mk(1, 8'h11, 0, 3'd4, 4'h0, 32'h0, 16'd0));
        tbl.push_back(mk(1, 8'h22, 0, 3'd4, 4'h0, 32'h0, 16'd0));
        tbl.push_back(mk(1, 8'h33, 0, 3'd4, 4'h0, 32'h0, 16'd0));
        tbl.push_back(mk(1, 8'h44, 0, 3'd4, 4'hF, 32'h44332211, 16'd1));
        tbl.push_back(mk(0, 8'h00, 0, 3'd4, 4'h0, 32'h0, 16'd1));
        // x2
        tbl.push_back(mk(1, 8'hA0, 0, 3'd2, 4'h0, 32'h0, 16'd1));
        tbl.push_back(mk(1, 8'hA1, 0, 3'd2, 4'h3, 32'hF7F7A1A0, 16'd2));
        tbl.push_back(mk(1, 8'hA2, 0, 3'd2, 4'h0, 32'h0, 16'd2));
        tbl.push_back(mk(1, 8'hA3, 0, 3'd2, 4'h3, 32'hF7F7A3A2, 16'd3));
        // x1: one group per cycle
        tbl.push_back(mk(1, 8'hB0, 0, 3'd1, 4'h1, 32'hF7F7F7B0, 16'd4));
        tbl.push_back(mk(1, 8'hB1, 0, 3'd1, 4'h1, 32'hF7F7F7B1, 16'd5));
        tbl.push_back(mk(1, 8'hB2, 0, 3'd1, 4'h1, 32'hF7F7F7B2, 16'd6));
        tbl.push_back(mk(0, 8'h00, 0, 3'd4, 4'h0, 32'h0, 16'd6));
        // width change mid-group is deferred
        tbl.push_back(mk(1, 8'hC0, 0, 3'd4, 4'h0, 32'h0, 16'd6));
        tbl.push_back(mk(1, 8'hC1, 0, 3'd4, 4'h0, 32'h0, 16'd6));
        tbl.push_back(mk(1, 8'hC2, 0, 3'd1, 4'h0, 32'h0, 16'd6));
        tbl.push_back(mk(1, 8'hC3, 0, 3'd1, 4'hF, 32'hC3C2C1C0, 16'd7));
        tbl.push_back(mk(1, 8'hC4, 0, 3'd1, 4'h1, 32'hF7F7F7C4, 16'd8));
        tbl.push_back(mk(0, 8'h00, 0, 3'd4, 4'h0, 32'h0, 16'd8));
        // flush without accept, then flush at ptr 0
        tbl.push_back(mk(1, 8'h55, 0, 3'd4, 4'h0, 32'h0, 16'd8));
        tbl.push_back(mk(1, 8'h66, 0, 3'd4, 4'h0, 32'h0, 16'd8));
        tbl.push_back(mk(0, 8'h00, 1, 3'd4, 4'h3, 32'hF7F76655, 16'd9));
        tbl.push_back(mk(0, 8'h00, 0, 3'd4, 4'h0, 32'h0, 16'd9));
        tbl.push_back(mk(0, 8'h00, 1, 3'd4, 4'h0, 32'h0, 16'd9));
        tbl.push_back(mk(0, 8'h00, 0, 3'd4, 4'h0, 32'h0, 16'd9));
        // flush with accept
        tbl.push_back(mk(1, 8'h77, 0, 3'd4, 4'h0, 32'h0, 16'd9));
        tbl.push_back(mk(1, 8'h88, 1, 3'd4, 4'h3, 32'hF7F78877, 16'd10));
        tbl.push_back(mk(0, 8'h00, 0, 3'd4, 4'h0, 32'h0, 16'd10));
        // flush coinciding with natural completion: a single launch
        tbl.push_back(mk(1, 8'h90, 0, 3'd2, 4'h0, 32'h0, 16'd10));
        tbl.push_back(mk(1, 8'h91, 1, 3'd2, 4'h3, 32'hF7F79190, 16'd11));
        tbl.push_back(mk(0, 8'h00, 1, 3'd2, 4'h0, 32'h0, 16'd11));
        // illegal width 3 decodes to 4
        tbl.push_back(mk(1, 8'hD0, 0, 3'd3, 4'h0, 32'h0, 16'd11));
        tbl.push_back(mk(1, 8'hD1, 0, 3'd3, 4'h0, 32'h0, 16'd11));
        tbl.push_back(mk(1, 8'hD2, 0, 3'd3, 4'h0, 32'h0, 16'd11));
        tbl.push_back(mk(1, 8'hD3, 0, 3'd3, 4'hF, 32'hD3D2D1D0, 16'd12));
        tbl.push_back(mk(0, 8'h00, 0, 3'd4, 4'h0, 32'h0, 16'd12));

        // Power-on reset
        reset = 1'b1; valid_in = 1'b0; data_in = 8'h00; flush = 1'b0;
        active_lanes = 3'd4; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset data_out", data_out, 32'h0);
        chk("reset valid_out", {28'd0, valid_out}, 32'h0);
        chk("reset group_cnt", {16'd0, group_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-reset ready_in", {31'd0, ready_in}, 32'd1);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].act, tbl[i].ordy);
            settle($sformatf("row%0d", i), tbl[i].rdy, tbl[i].vo, tbl[i].dout, tbl[i].cnt);
        end

        // Backpressure: group presented with out_ready low
        drive(1, 8'hE0, 0, 3'd4, 0); settle("bp E0", 1, 4'h0, 32'h0, 16'd12);
        drive(1, 8'hE1, 0, 3'd4, 0); settle("bp E1", 1, 4'h0, 32'h0, 16'd12);
        drive(1, 8'hE2, 0, 3'd4, 0); settle("bp E2", 1, 4'h0, 32'h0, 16'd12);
        drive(1, 8'hE3, 0, 3'd4, 0); settle("bp E3", 1, 4'hF, 32'hE3E2E1E0, 16'd13);
        for (int k = 0; k < 5; k++) begin
            drive(1, 8'hEE, 1, 3'd4, 0);
            settle($sformatf("bp hold%0d", k), 0, 4'hF, 32'hE3E2E1E0, 16'd13);
        end
        // Release together with a completing x1 group: replaced, no bubble
        drive(1, 8'hF0, 0, 3'd1, 1); settle("bp release", 1, 4'h1, 32'hF7F7F7F0, 16'd14);
        // The held EE bytes must not show up in the next group
        drive(1, 8'hF1, 0, 3'd4, 1); settle("bp F1", 1, 4'h0, 32'h0, 16'd14);
        drive(1, 8'hF2, 0, 3'd4, 1); settle("bp F2", 1, 4'h0, 32'h0, 16'd14);
        drive(1, 8'hF3, 0, 3'd4, 1); settle("bp F3", 1, 4'h0, 32'h0, 16'd14);
        drive(1, 8'hF4, 0, 3'd4, 1); settle("bp F4", 1, 4'hF, 32'hF4F3F2F1, 16'd15);

        // Reset mid-group discards the partial group
        drive(1, 8'h01, 0, 3'd4, 1); settle("rst 01", 1, 4'h0, 32'h0, 16'd15);
        drive(1, 8'h02, 0, 3'd4, 1); settle("rst 02", 1, 4'h0, 32'h0, 16'd15);
        drive(1, 8'h03, 0, 3'd4, 1); settle("rst 03", 1, 4'h0, 32'h0, 16'd15);
        drive(0, 8'h00, 0, 3'd4, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst data_out", data_out, 32'h0);
        chk("midrst valid_out", {28'd0, valid_out}, 32'h0);
        chk("midrst group_cnt", {16'd0, group_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 8'h0A, 0, 3'd4, 1); settle("new 0A", 1, 4'h0, 32'h0, 16'd0);
        drive(1, 8'h0B, 0, 3'd4, 1); settle("new 0B", 1, 4'h0, 32'h0, 16'd0);
        drive(1, 8'h0C, 0, 3'd4, 1); settle("new 0C", 1, 4'h0, 32'h0, 16'd0);
        drive(1, 8'h0D, 0, 3'd4, 1); settle("new 0D", 1, 4'hF, 32'h0D0C0B0A, 16'd1);
        drive(0, 8'h00, 0, 3'd4, 1); settle("new idle", 1, 4'h0, 32'h0, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
